// File: rtl/instruction_prefetch_unit.sv
// Instruction prefetch unit: the fetch front end upstream of IF/ID.
// Issues sequential word reads to a request/response program memory and
// buffers the returned words with their PC in an in-order FIFO. Decode
// consumes one instruction per cycle with valid/ready handshaking. A
// redirect flushes buffered and in-flight instructions and refetches
// from the target address.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   mem_req_o           read request valid
//   mem_addr_o          read address (word aligned)
//   mem_ready_i         memory accepts the request this cycle
//   mem_rvalid_i        read data valid (responses return in request order)
//   mem_rdata_i         instruction word
//   redirect_i          flush and refetch from redirect_pc_i
//   redirect_pc_i       new fetch address
//   inst_valid_o        instruction available to decode
//   inst_ready_i        decode consumes the instruction this cycle
//   inst_o, pc_o, pc4_o instruction at the FIFO head, its PC and PC + 4
module instruction_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic          head_loaded;

    logic          fifo_empty;
    logic [CW:0]   credit_used;
    logic          issue;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_aligned;

    // Credits cover both buffered words and requests still in flight, so
    // every response is guaranteed a free FIFO slot.
    assign credit_used      = {1'b0, fifo_count} + {1'b0, outstanding};
    assign fifo_empty       = (fifo_count == '0);
    assign redirect_aligned = {redirect_pc_i[31:2], 2'b00};

    assign mem_req_o    = !reset && !redirect_i && (credit_used < DEPTH_W);
    assign mem_addr_o   = fetch_pc;
    assign issue        = mem_req_o && mem_ready_i;
    assign push         = mem_rvalid_i && (discard == '0);
    assign inst_valid_o = !reset && !fifo_empty && !redirect_i;
    assign pop          = inst_valid_o && inst_ready_i;

    assign inst_o = fifo_inst[rd_ptr];
    assign pc_o   = fifo_pc[rd_ptr];
    // pc4_o reads 0 until the first word ever lands in the FIFO.
    assign pc4_o  = head_loaded ? fifo_pc[rd_ptr] + 32'd4 : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            discard     <= '0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            head_loaded <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_inst[i] <= '0;
            end
        end else if (redirect_i) begin
            // The response arriving in this cycle is itself stale, so it
            // is retired here and excluded from the discard count.
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= outstanding - CW'(mem_rvalid_i);
            discard     <= outstanding - CW'(mem_rvalid_i);
            fetch_pc    <= redirect_aligned;
            rsp_pc      <= redirect_aligned;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(mem_rvalid_i);
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (mem_rvalid_i && (discard != '0)) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                fifo_pc[wr_ptr]   <= rsp_pc;
                fifo_inst[wr_ptr] <= mem_rdata_i;
                wr_ptr            <= wr_ptr + AW'(1);
                rsp_pc            <= rsp_pc + 32'd4;
                head_loaded       <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    a_credit_bound: assert property (@(posedge clk) disable iff (reset)
        credit_used <= DEPTH_W);
    a_discard_bound: assert property (@(posedge clk) disable iff (reset)
        discard <= outstanding);
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        mem_rvalid_i |-> (outstanding != '0));

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
module tb_instruction_prefetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] MASK     = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic [31:0] pc4_o;

    instruction_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ready_i(mem_ready_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .pc_o(pc_o), .pc4_o(pc4_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    req_t        mq[$];        // bench memory: accepted requests awaiting response
    ent_t        sb[$];        // scoreboard: expected FIFO contents in order
    logic [31:0] dq[$];        // delivered PCs (for directed checks)
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          m_out = 0;
    int          m_disc = 0;
    logic [31:0] m_fetch = RESET_PC;
    logic [31:0] m_rsp = RESET_PC;
    int          accepted = 0;
    int          first_req = -1;
    int          first_valid = -1;
    int          n_delivered = 0;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, update model at posedge.
    task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc, input logic irdy);
        logic        rv;
        logic        exp_req;
        logic        exp_valid;
        logic        issue_dut;
        logic [31:0] addr_s;
        int          due;
        mem_ready_i   = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        inst_ready_i  = irdy;
        rv = (mq.size() > 0) && (mq[0].due <= cyc);
        mem_rvalid_i = rv;
        mem_rdata_i  = rv ? (mq[0].addr ^ MASK) : 32'hDEAD_BEEF;
        #4;
        exp_req = !redir && ((sb.size() + m_out) < DEPTH);
        check32("mem_req", {31'b0, mem_req_o}, {31'b0, exp_req});
        if (exp_req) check32("mem_addr", mem_addr_o, m_fetch);
        exp_valid = (sb.size() > 0) && !redir;
        check32("inst_valid", {31'b0, inst_valid_o}, {31'b0, exp_valid});
        if (exp_valid) begin
            check32("pc", pc_o, sb[0].pc);
            check32("inst", inst_o, sb[0].inst);
            check32("pc4", pc4_o, sb[0].pc + 32'd4);
        end
        if (mem_req_o && first_req < 0) first_req = cyc;
        if (inst_valid_o && first_valid < 0) first_valid = cyc;
        issue_dut = mem_req_o && rdy;
        addr_s    = mem_addr_o;
        @(posedge clk);
        if (rv) void'(mq.pop_front());
        if (issue_dut) begin
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{addr_s, due});
            accepted++;
        end
        if (redir) begin
            sb.delete();
            m_out   = m_out - int'(rv);
            m_disc  = m_out;
            m_fetch = {rpc[31:2], 2'b00};
            m_rsp   = m_fetch;
        end else begin
            if (exp_valid && irdy) begin
                dq.push_back(sb[0].pc);
                n_delivered++;
                void'(sb.pop_front());
            end
            if (rv) begin
                m_out--;
                if (m_disc > 0) m_disc--;
                else begin
                    sb.push_back('{m_rsp, m_rsp ^ MASK});
                    m_rsp += 32'd4;
                end
            end
            if (exp_req && rdy) begin
                m_out++;
                m_fetch += 32'd4;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; inst_ready_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            #4;
            check32("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
            check32("rst_inst_valid", {31'b0, inst_valid_o}, 32'd0);
            @(posedge clk);
            cyc++;
            #1;
        end
        reset = 1'b0;
        mq.delete(); sb.delete(); dq.delete();
        m_out = 0; m_disc = 0; m_fetch = RESET_PC; m_rsp = RESET_PC;
        last_due = cyc; accepted = 0; first_req = -1; first_valid = -1; n_delivered = 0;
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset values and streaming with a 1-cycle memory.
        do_reset(2);
        check32("empty_inst", inst_o, 32'd0);
        check32("empty_pc", pc_o, 32'd0);
        check32("empty_pc4", pc4_o, 32'd0);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0, 1'b1);
        check32("first_req_cycle", 32'(first_req), 32'(cyc - 12));
        check32("req_to_valid", 32'(first_valid - first_req), 32'd2);
        check32("stream_count", 32'(n_delivered), 32'd10);

        // Decode stall fills the FIFO, then drains in order.
        do_reset(1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0);
        check32("stall_accepted", 32'(accepted), DEPTH);
        check32("stall_req_low", {31'b0, mem_req_o}, 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b1);
        check32("drain_timeout", {31'b0, dq.size() >= 4}, 32'd1);
        if (dq.size() >= 4)
            for (int i = 0; i < 4; i++) check32("drain_pc", dq[i], RESET_PC + 32'(4 * i));

        // 3-cycle memory, redirect with three requests in flight.
        do_reset(1);
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 32'h0040_0100, 1'b1);
        dq.delete();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0, 1'b1);
        check32("redir_timeout", {31'b0, dq.size() > 0}, 32'd1);
        if (dq.size() > 0) check32("redir_first_pc", dq[0], 32'h0040_0100);

        // Redirect colliding with a response and a pending pop.
        do_reset(1);
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b1, 32'h0040_0200, 1'b1);
        redirect_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        check32("post_redir_empty", {31'b0, inst_valid_o}, 32'd0);
        check32("post_redir_addr", mem_addr_o, 32'h0040_0200);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);

        // Unaligned redirect target is word aligned.
        step(1'b1, 1'b1, 32'h0040_0103, 1'b1);
        redirect_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        check32("align_addr", mem_addr_o, 32'h0040_0100);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b1);

        // Random ready, latency and redirects against the model.
        do_reset(1);
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(3, 0) != 0, $urandom_range(24, 0) == 0,
                 RESET_PC | ($urandom & 32'h0000_0FFF), $urandom_range(3, 0) != 0);
        end
        check32("random_progress", {31'b0, n_delivered > 1000}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
